// File: rtl/processorci_bridge_pkg.sv
// Shared types and constants for the processorci data-port bridges.
package processorci_bridge_pkg;

  // Bridge transaction phases: idle, Wishbone cycle in progress, core response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  // Read data handed back to the core when the bus never answers.
  localparam logic [31:0] BRIDGE_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/kronos_wb_data_bridge_watchdog.sv
// bus_watchdog: counts cycles spent waiting on wb_ack and flags expiry.
// Only compiled when DATA_BRIDGE_TIMEOUT_EN is defined; the bridge instantiates it under that macro.
`ifdef DATA_BRIDGE_TIMEOUT_EN
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Expiry is raised during the TIMEOUT_CYCLES-th waiting cycle, so cyc is held that many cycles.
  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared when a transaction is accepted, advances while the bus is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/kronos_wb_data_bridge.sv
// kronos_wb_data_bridge: Kronos core data port (req held until ack) to Wishbone-classic master.
// One transaction in flight; all outputs registered.
// Optional wb_ack timeout enabled by defining DATA_BRIDGE_TIMEOUT_EN.
module kronos_wb_data_bridge
  import processorci_bridge_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA      = BRIDGE_ERR_RDATA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wr_data,
  input  logic [DATA_WIDTH/8-1:0] core_mask,
  input  logic                    core_wr_en,
  input  logic                    core_req,
  output logic [DATA_WIDTH-1:0]   core_rd_data,
  output logic                    core_ack,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [ADDR_WIDTH-1:0]   wb_addr,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack,
  output logic                    bus_error
);

  bridge_state_t state, state_next;
  logic          accept;
  logic          bus_done;
  logic          bus_expired;
  logic [1:0]    unused_addr_lsb;

  // Byte offset is dropped: the bus is word addressed and wb_sel carries the lane.
  assign unused_addr_lsb = core_addr[1:0];

`ifdef DATA_BRIDGE_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .run    (state == BUS),
    .expired(bus_expired)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign bus_expired        = 1'b0;
`endif

  // Next-state logic: req sampled only in IDLE; BUS exits on wb_ack or watchdog expiry.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bus_done   = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wb_ack || bus_expired) begin
          bus_done   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output registers: request capture on accept, response capture on bus completion.
  // wb_ack takes priority over a coincident expiry, so bus_error only fires without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rd_data <= '0;
      core_ack     <= 1'b0;
      bus_error    <= 1'b0;
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_sel       <= '0;
      wb_addr      <= '0;
      wb_data_o    <= '0;
    end else begin
      core_ack  <= 1'b0;
      bus_error <= 1'b0;
      if (accept) begin
        wb_cyc    <= 1'b1;
        wb_stb    <= 1'b1;
        wb_we     <= core_wr_en;
        wb_sel    <= core_mask;
        wb_addr   <= {core_addr[ADDR_WIDTH-1:2], 2'b00};
        wb_data_o <= core_wr_data;
      end
      if (bus_done) begin
        wb_cyc    <= 1'b0;
        wb_stb    <= 1'b0;
        core_ack  <= 1'b1;
        bus_error <= !wb_ack;
        if (wb_ack) begin
          core_rd_data <= wb_we ? '0 : wb_data_i;
        end else begin
          core_rd_data <= ERR_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_kronos_wb_data_bridge.sv
// Scoreboard bench for kronos_wb_data_bridge: stimulus pushes expected bus/response records,
// a negedge monitor pops and compares whenever wb_cyc rises or core_ack is seen.
module tb_kronos_wb_data_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] core_addr;
  logic [31:0] core_wr_data;
  logic [3:0]  core_mask;
  logic        core_wr_en;
  logic        core_req;
  logic [31:0] core_rd_data;
  logic        core_ack;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rsp_exp_t;

  wb_exp_t  wbq[$];
  rsp_exp_t rspq[$];

  kronos_wb_data_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_addr   (core_addr),
    .core_wr_data(core_wr_data),
    .core_mask   (core_mask),
    .core_wr_en  (core_wr_en),
    .core_req    (core_req),
    .core_rd_data(core_rd_data),
    .core_ack    (core_ack),
    .wb_cyc      (wb_cyc),
    .wb_stb      (wb_stb),
    .wb_we       (wb_we),
    .wb_sel      (wb_sel),
    .wb_addr     (wb_addr),
    .wb_data_o   (wb_data_o),
    .wb_data_i   (wb_data_i),
    .wb_ack      (wb_ack),
    .bus_error   (bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor: compares each new bus cycle and each core response against the scoreboard.
  initial begin
    logic     prev_cyc;
    wb_exp_t  we_e;
    rsp_exp_t rs_e;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cyc = 1'b0;
      end else begin
        if (wb_cyc && !prev_cyc) begin
          if (wbq.size() == 0) begin
            fail("wb_unexpected_cycle");
          end else begin
            we_e = wbq.pop_front();
            check("wb_addr", wb_addr, we_e.addr);
            check("wb_we", 32'(wb_we), 32'(we_e.we));
            check("wb_sel", 32'(wb_sel), 32'(we_e.sel));
            check("wb_data_o", wb_data_o, we_e.data);
            check("wb_stb", 32'(wb_stb), 32'd1);
          end
        end
        if (core_ack) begin
          if (rspq.size() == 0) begin
            fail("core_ack_unexpected");
          end else begin
            rs_e = rspq.pop_front();
            check("core_rd_data", core_rd_data, rs_e.rd);
            check("bus_error", 32'(bus_error), 32'(rs_e.err));
          end
        end else if (bus_error) begin
          fail("bus_error_without_ack");
        end
        prev_cyc = wb_cyc;
      end
    end
  end

  // One core transaction with a slave that acks after 'waits' stall cycles.
  // Called at #1 after a posedge; returns at #1 after the edge entering RESP.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                     input logic we, input logic [31:0] rdata, input int waits, input bit keep,
                     input int exp_lat);
    wb_exp_t  e;
    rsp_exp_t r;
    int       n;
    e.addr = {addr[31:2], 2'b00};
    e.we   = we;
    e.sel  = mask;
    e.data = wdata;
    r.rd   = we ? 32'h0 : rdata;
    r.err  = 1'b0;
    wbq.push_back(e);
    rspq.push_back(r);
    core_addr    = addr;
    core_wr_data = wdata;
    core_mask    = mask;
    core_wr_en   = we;
    core_req     = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_cyc && n < 10);
    if (!wb_cyc) begin
      fail("wait_wb_cyc_expired");
      core_req = 1'b0;
      return;
    end
    check("stb_latency", 32'(n), 32'(exp_lat));
    for (int i = 0; i < waits; i++) begin
      check("hold_cyc", 32'(wb_cyc), 32'd1);
      check("hold_addr", wb_addr, e.addr);
      check("hold_we", 32'(wb_we), 32'(we));
      check("hold_sel", 32'(wb_sel), 32'(mask));
      check("hold_data", wb_data_o, wdata);
      check("no_early_ack", 32'(core_ack), 32'd0);
      @(posedge clk);
      #1;
    end
    check("cyc_before_ack", 32'(wb_cyc), 32'd1);
    wb_ack    = 1'b1;
    wb_data_i = rdata;
    @(posedge clk);
    #1;
    wb_ack    = 1'b0;
    wb_data_i = 32'h5A5A_A5A5;
    check("ack_latency", 32'(core_ack), 32'd1);
    check("cyc_dropped", 32'(wb_cyc), 32'd0);
    if (!keep) core_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
    check({tag, "_stb"}, 32'(wb_stb), 32'd0);
    check({tag, "_we"}, 32'(wb_we), 32'd0);
    check({tag, "_sel"}, 32'(wb_sel), 32'd0);
    check({tag, "_addr"}, wb_addr, 32'd0);
    check({tag, "_data_o"}, wb_data_o, 32'd0);
    check({tag, "_ack"}, 32'(core_ack), 32'd0);
    check({tag, "_rd"}, core_rd_data, 32'd0);
    check({tag, "_err"}, 32'(bus_error), 32'd0);
  endtask

  // Absolute time guard in case a wait escapes its bound.
  initial begin
    #200000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst          = 1'b1;
    core_addr    = '0;
    core_wr_data = '0;
    core_mask    = '0;
    core_wr_en   = 1'b0;
    core_req     = 1'b0;
    wb_data_i    = '0;
    wb_ack       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load, zero-wait slave.
    txn(32'h0000_0104, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 0, 1'b0, 1);
    @(posedge clk);
    #1;
    check("rd_hold_load", core_rd_data, 32'h1234_5678);
    check("ack_one_cycle", 32'(core_ack), 32'd0);

    // Byte store to an unaligned address; stores return zero read data.
    txn(32'h0000_0203, 32'hAB00_0000, 4'b1000, 1'b1, 32'h9999_9999, 0, 1'b0, 1);
    @(posedge clk);
    #1;
    check("rd_hold_store", core_rd_data, 32'h0);

    // Five wait states.
    txn(32'h0000_0308, 32'h0, 4'b0011, 1'b0, 32'hCAFE_F00D, 5, 1'b0, 1);
    @(posedge clk);
    #1;

    // Back-to-back loads with req held across both.
    txn(32'h0000_0400, 32'h0, 4'hF, 1'b0, 32'h1111_1111, 0, 1'b1, 1);
    txn(32'h0000_0404, 32'h0, 4'hF, 1'b0, 32'h2222_2222, 2, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_cycle", 32'(wb_cyc), 32'd0);

    // Reset while the slave is stalling.
    wbq.push_back('{addr: 32'h0000_0500, we: 1'b1, sel: 4'b0011, data: 32'h0000_5555});
    core_addr    = 32'h0000_0501;
    core_wr_data = 32'h0000_5555;
    core_mask    = 4'b0011;
    core_wr_en   = 1'b1;
    core_req     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_cyc", 32'(wb_cyc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    core_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_ack", 32'(core_ack), 32'd0);
    txn(32'h0000_0510, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1, 1'b0, 1);
    @(posedge clk);
    #1;

    // Slave that never acknowledges.
    wbq.push_back('{addr: 32'h0000_0600, we: 1'b0, sel: 4'hF, data: 32'h0});
    core_addr    = 32'h0000_0600;
    core_wr_data = 32'h0;
    core_mask    = 4'hF;
    core_wr_en   = 1'b0;
    core_req     = 1'b1;
    @(posedge clk);
    #1;
    check("noack_cyc_start", 32'(wb_cyc), 32'd1);
`ifdef DATA_BRIDGE_TIMEOUT_EN
    rspq.push_back('{rd: 32'hDEAD_BEEF, err: 1'b1});
    n = 0;
    while (wb_cyc && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("timeout_cyc_cycles", 32'(n), 32'd8);
    check("timeout_ack", 32'(core_ack), 32'd1);
    check("timeout_err", 32'(bus_error), 32'd1);
    core_req = 1'b0;
    @(posedge clk);
    #1;
    check("timeout_err_pulse", 32'(bus_error), 32'd0);
    check("timeout_rd_hold", core_rd_data, 32'hDEAD_BEEF);
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (wb_cyc && !core_ack) n++;
    end
    check("noack_cyc_held_cycles", 32'(n), 32'd40);
    check("noack_err", 32'(bus_error), 32'd0);
    core_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    // Normal traffic still works afterwards.
    txn(32'h0000_0700, 32'h0, 4'hF, 1'b0, 32'h7777_0000, 0, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("wbq_drained", 32'(wbq.size()), 32'd0);
    check("rspq_drained", 32'(rspq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
